// File: rtl/memory_port_arbiter.sv
// Two-master arbiter that shares a single-port SRAM (read latency 1) between
// an instruction side and a data side, with round-robin or fixed-data priority.
module memory_port_arbiter #(
    parameter logic ROUND_ROBIN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        inst_request,
    input  logic [3:0]  inst_write_strobe,
    input  logic [31:0] inst_address,
    input  logic [31:0] inst_write_data,
    output logic        inst_grant,
    output logic        inst_read_valid,
    output logic [31:0] inst_read_data,

    input  logic        data_request,
    input  logic [3:0]  data_write_strobe,
    input  logic [31:0] data_address,
    input  logic [31:0] data_write_data,
    output logic        data_grant,
    output logic        data_read_valid,
    output logic [31:0] data_read_data,

    output logic        ram_enabled,
    output logic [3:0]  ram_write_strobe,
    output logic [31:0] ram_address,
    output logic [31:0] ram_write_data,
    input  logic [31:0] ram_read_data
);

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    logic        r_last_owner;
    logic        r_read_pending;
    logic        r_read_owner;

    logic        w_inst_grant;
    logic        w_data_grant;
    logic [3:0]  w_sel_strobe;
    logic [31:0] w_sel_address;
    logic [31:0] w_sel_write_data;
    logic        w_inst_valid;
    logic        w_data_valid;

    // Grant decision: a lone requester wins at once; on conflict the loser stalls.
    always_comb begin
        w_inst_grant = 1'b0;
        w_data_grant = 1'b0;
        if (reset) begin
            w_inst_grant = 1'b0;
            w_data_grant = 1'b0;
        end else if (inst_request && data_request) begin
            if (ROUND_ROBIN) begin
                w_data_grant = (r_last_owner == OWNER_INST);
            end else begin
                w_data_grant = 1'b1;
            end
            w_inst_grant = !w_data_grant;
        end else begin
            w_inst_grant = inst_request;
            w_data_grant = data_request;
        end
    end

    // Steer the winning side onto the SRAM port; idle port is driven to zero.
    always_comb begin
        w_sel_strobe     = 4'h0;
        w_sel_address    = 32'h0000_0000;
        w_sel_write_data = 32'h0000_0000;
        case ({w_data_grant, w_inst_grant})
            2'b10: begin
                w_sel_strobe     = data_write_strobe;
                w_sel_address    = data_address;
                w_sel_write_data = data_write_data;
            end
            2'b01: begin
                w_sel_strobe     = inst_write_strobe;
                w_sel_address    = inst_address;
                w_sel_write_data = inst_write_data;
            end
            default: begin
                w_sel_strobe     = 4'h0;
                w_sel_address    = 32'h0000_0000;
                w_sel_write_data = 32'h0000_0000;
            end
        endcase
    end

    // Ownership history and the one-deep read-return tracker.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_owner   <= OWNER_INST;
            r_read_pending <= 1'b0;
            r_read_owner   <= OWNER_INST;
        end else if (w_inst_grant || w_data_grant) begin
            r_last_owner   <= w_data_grant ? OWNER_DATA : OWNER_INST;
            r_read_pending <= (w_sel_strobe == 4'h0);
            r_read_owner   <= w_data_grant ? OWNER_DATA : OWNER_INST;
        end else begin
            r_read_pending <= 1'b0;
        end
    end

    // Reset also masks a return already in flight so nothing leaks out mid-reset.
    assign w_inst_valid = r_read_pending && (r_read_owner == OWNER_INST) && !reset;
    assign w_data_valid = r_read_pending && (r_read_owner == OWNER_DATA) && !reset;

    assign inst_grant       = w_inst_grant;
    assign data_grant       = w_data_grant;
    assign ram_enabled      = w_inst_grant | w_data_grant;
    assign ram_write_strobe = w_sel_strobe;
    assign ram_address      = w_sel_address;
    assign ram_write_data   = w_sel_write_data;

    assign inst_read_valid  = w_inst_valid;
    assign inst_read_data   = w_inst_valid ? ram_read_data : 32'h0000_0000;
    assign data_read_valid  = w_data_valid;
    assign data_read_data   = w_data_valid ? ram_read_data : 32'h0000_0000;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: a fixed-priority (index 0) and a round-robin
// (index 1) instance share stimulus and are checked against a side-level model.
module tb_memory_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        inst_request, data_request;
    logic [3:0]  inst_write_strobe, data_write_strobe;
    logic [31:0] inst_address, inst_write_data, data_address, data_write_data;
    logic [31:0] ram_read_data;

    logic [1:0]        ig, dg, en, irv, drv;
    logic [1:0][3:0]   ws;
    logic [1:0][31:0]  ra, wd, ird, drd;

    int tests = 0;
    int fails = 0;

    // Model state per instance: side names are 0 none, 1 inst, 2 data.
    int last_side [2];
    int ret_side  [2];
    int cur_win   [2];

    always #5 clock = ~clock;

    memory_port_arbiter #(.ROUND_ROBIN(1'b0)) u_fx (
        .clock(clock), .reset(reset),
        .inst_request(inst_request), .inst_write_strobe(inst_write_strobe),
        .inst_address(inst_address), .inst_write_data(inst_write_data),
        .inst_grant(ig[0]), .inst_read_valid(irv[0]), .inst_read_data(ird[0]),
        .data_request(data_request), .data_write_strobe(data_write_strobe),
        .data_address(data_address), .data_write_data(data_write_data),
        .data_grant(dg[0]), .data_read_valid(drv[0]), .data_read_data(drd[0]),
        .ram_enabled(en[0]), .ram_write_strobe(ws[0]), .ram_address(ra[0]),
        .ram_write_data(wd[0]), .ram_read_data(ram_read_data)
    );

    memory_port_arbiter #(.ROUND_ROBIN(1'b1)) u_rr (
        .clock(clock), .reset(reset),
        .inst_request(inst_request), .inst_write_strobe(inst_write_strobe),
        .inst_address(inst_address), .inst_write_data(inst_write_data),
        .inst_grant(ig[1]), .inst_read_valid(irv[1]), .inst_read_data(ird[1]),
        .data_request(data_request), .data_write_strobe(data_write_strobe),
        .data_address(data_address), .data_write_data(data_write_data),
        .data_grant(dg[1]), .data_read_valid(drv[1]), .data_read_data(drd[1]),
        .ram_enabled(en[1]), .ram_write_strobe(ws[1]), .ram_address(ra[1]),
        .ram_write_data(wd[1]), .ram_read_data(ram_read_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Which side should win right now, given the model's memory of the last winner.
    function automatic int winner(input int k);
        if (reset) return 0;
        if (inst_request && data_request) begin
            if (k == 1) return (last_side[k] == 2) ? 1 : 2;
            return 2;
        end
        if (inst_request) return 1;
        if (data_request) return 2;
        return 0;
    endfunction

    // Compare every output of both instances each cycle, away from the clock edge.
    always @(negedge clock) begin
        int w, r;
        logic [3:0]  es;
        logic [31:0] ea, ed;
        for (int k = 0; k < 2; k++) begin
            w = winner(k);
            cur_win[k] = w;
            r = reset ? 0 : ret_side[k];
            es = (w == 1) ? inst_write_strobe : (w == 2) ? data_write_strobe : 4'h0;
            ea = (w == 1) ? inst_address      : (w == 2) ? data_address      : 32'h0;
            ed = (w == 1) ? inst_write_data   : (w == 2) ? data_write_data   : 32'h0;
            chk($sformatf("m%0d_inst_grant", k), {31'h0, ig[k]}, {31'h0, (w == 1)});
            chk($sformatf("m%0d_data_grant", k), {31'h0, dg[k]}, {31'h0, (w == 2)});
            chk($sformatf("m%0d_ram_en", k),     {31'h0, en[k]}, {31'h0, (w != 0)});
            chk($sformatf("m%0d_ram_strobe", k), {28'h0, ws[k]}, {28'h0, es});
            chk($sformatf("m%0d_ram_addr", k),   ra[k], ea);
            chk($sformatf("m%0d_ram_wdata", k),  wd[k], ed);
            chk($sformatf("m%0d_inst_rvalid", k), {31'h0, irv[k]}, {31'h0, (r == 1)});
            chk($sformatf("m%0d_data_rvalid", k), {31'h0, drv[k]}, {31'h0, (r == 2)});
            chk($sformatf("m%0d_inst_rdata", k), ird[k], (r == 1) ? ram_read_data : 32'h0);
            chk($sformatf("m%0d_data_rdata", k), drd[k], (r == 2) ? ram_read_data : 32'h0);
        end
    end

    // Advance the model: remember the winner and whether a read return is owed.
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                last_side[k] = 1;
                ret_side[k]  = 0;
            end else if (cur_win[k] != 0) begin
                last_side[k] = cur_win[k];
                ret_side[k]  = (((cur_win[k] == 1) ? inst_write_strobe : data_write_strobe) == 4'h0)
                               ? cur_win[k] : 0;
            end else begin
                ret_side[k] = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input logic ir, input logic [3:0] is, input logic [31:0] ia,
                           input logic dr, input logic [3:0] ds, input logic [31:0] da);
        inst_request = ir; inst_write_strobe = is; inst_address = ia;
        inst_write_data = ia ^ 32'h5a5a_0000;
        data_request = dr; data_write_strobe = ds; data_address = da;
        data_write_data = da ^ 32'h0000_a5a5;
    endtask

    logic [5:0] pat_rr;
    logic       en_all;

    initial begin
        cur_win[0] = 0; cur_win[1] = 0;
        last_side[0] = 1; last_side[1] = 1;
        ret_side[0] = 0; ret_side[1] = 0;
        reset = 1'b1;
        ram_read_data = 32'h0;
        set_req(1'b1, 4'h0, 32'h10, 1'b1, 4'h0, 32'h20);
        tick();
        @(negedge clock);
        chk("rst_grants", {30'h0, ig[1], dg[1]}, 32'h0);
        chk("rst_ram_en", {30'h0, en}, 32'h0);
        tick();

        // Inst-only read, returned next cycle.
        reset = 1'b0;
        set_req(1'b1, 4'h0, 32'hbfc0_0000, 1'b0, 4'h0, 32'h0);
        @(negedge clock);
        chk("iread_grant", {31'h0, ig[1]}, 32'h1);
        chk("iread_addr", ra[1], 32'hbfc0_0000);
        chk("iread_no_dgrant", {31'h0, dg[1]}, 32'h0);
        tick();
        set_req(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        ram_read_data = 32'h3c1d_0001;
        @(negedge clock);
        chk("iread_valid", {31'h0, irv[1]}, 32'h1);
        chk("iread_data", ird[1], 32'h3c1d_0001);
        chk("iread_no_dvalid", {31'h0, drv[1]}, 32'h0);
        tick();

        // First conflict after reset: data then inst, each gets its own return.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(1'b1, 4'h0, 32'h100, 1'b1, 4'h0, 32'h200);
        @(negedge clock);
        chk("c0_dgrant", {31'h0, dg[1]}, 32'h1);
        chk("c0_addr", ra[1], 32'h200);
        tick();
        set_req(1'b1, 4'h0, 32'h100, 1'b0, 4'h0, 32'h0);
        ram_read_data = 32'h1111_1111;
        @(negedge clock);
        chk("c1_igrant", {31'h0, ig[1]}, 32'h1);
        chk("c1_dvalid", {31'h0, drv[1]}, 32'h1);
        chk("c1_ddata", drd[1], 32'h1111_1111);
        tick();
        set_req(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        ram_read_data = 32'h2222_2222;
        @(negedge clock);
        chk("c2_ivalid", {31'h0, irv[1]}, 32'h1);
        chk("c2_idata", ird[1], 32'h2222_2222);
        tick();

        // Sustained conflict: alternation on RR, data always on fixed priority.
        pat_rr = 6'h0;
        en_all = 1'b1;
        for (int c = 0; c < 6; c++) begin
            set_req(1'b1, 4'h0, 32'h400, 1'b1, 4'h0, 32'h800);
            ram_read_data = 32'h9000_0000 + c;
            @(negedge clock);
            pat_rr = {pat_rr[4:0], dg[1]};
            en_all = en_all & en[1] & en[0];
            if (c < 4) begin
                chk("fixed_dgrant", {31'h0, dg[0]}, 32'h1);
                chk("fixed_no_igrant", {31'h0, ig[0]}, 32'h0);
            end
            tick();
        end
        chk("rr_pattern_DIDIDI", {26'h0, pat_rr}, 32'h2a);
        chk("conflict_ram_en", {31'h0, en_all}, 32'h1);

        // Data write then back-to-back inst read: no read return for the write.
        set_req(1'b0, 4'h0, 32'h0, 1'b1, 4'hf, 32'h1000);
        data_write_data = 32'hdead_beef;
        @(negedge clock);
        chk("dwr_strobe", {28'h0, ws[1]}, 32'hf);
        chk("dwr_addr", ra[1], 32'h1000);
        chk("dwr_data", wd[1], 32'hdead_beef);
        tick();
        set_req(1'b1, 4'h0, 32'h40, 1'b0, 4'h0, 32'h0);
        @(negedge clock);
        chk("dwr_no_dvalid", {31'h0, drv[1]}, 32'h0);
        chk("b2b_igrant", {31'h0, ig[1]}, 32'h1);
        tick();
        set_req(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        ram_read_data = 32'h55aa_55aa;
        @(negedge clock);
        chk("b2b_ivalid", {31'h0, irv[1]}, 32'h1);
        tick();

        // Reset right after a data read grant: the return is dropped, priority restarts.
        set_req(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h300);
        tick();
        set_req(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        reset = 1'b1;
        ram_read_data = 32'hcafe_f00d;
        @(negedge clock);
        chk("rst_mid_dvalid", {31'h0, drv[1]}, 32'h0);
        chk("rst_mid_ddata", drd[1], 32'h0);
        chk("rst_mid_en", {31'h0, en[1]}, 32'h0);
        tick();
        reset = 1'b0;
        set_req(1'b1, 4'h0, 32'h500, 1'b1, 4'h0, 32'h600);
        @(negedge clock);
        chk("post_rst_dgrant", {31'h0, dg[1]}, 32'h1);
        chk("post_rst_no_igrant", {31'h0, ig[1]}, 32'h0);
        tick();

        // Mixed traffic, checked purely by the model.
        for (int c = 0; c < 60; c++) begin
            reset = ($urandom_range(0, 15) == 0);
            set_req($urandom_range(0, 1) == 1,
                    ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0,
                    $urandom,
                    $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0,
                    $urandom);
            ram_read_data = $urandom;
            tick();
        end
        reset = 1'b0;
        set_req(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        tick();
        @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/memory_port_arbiter.md
MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

Interface
REQ-001 SHALL have parameter ROUND_ROBIN, default 1: 1 = alternate grants on conflict; 0 = fixed data priority.
REQ-002 SHALL have port clock, input, 1: the single clock; all state updates on posedge.
REQ-003 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-004 SHALL have port inst_request, input, 1: instruction-side access request.
REQ-005 SHALL have port inst_write_strobe, input, 4: byte write enables; 0 means read.
REQ-006 SHALL have ports inst_address and inst_write_data, input, 32 each.
REQ-007 SHALL have port inst_grant, output, 1: request accepted this cycle.
REQ-008 SHALL have ports inst_read_valid (output, 1) and inst_read_data (output, 32): read return.
REQ-009 SHALL have ports data_request, data_write_strobe, data_address, data_write_data, data_grant, data_read_valid and data_read_data, with the same widths and meanings as the inst_* ports.
REQ-010 SHALL have ports ram_enabled (output, 1), ram_write_strobe (output, 4), ram_address (output, 32), ram_write_data (output, 32) and ram_read_data (input, 32): the shared single-port SRAM, read latency 1.

Function
REQ-011 SHALL grant at most one requester per cycle; grants are combinational from the current requests and the last_owner register.
REQ-012 SHALL grant a sole requester in the same cycle it asserts request.
REQ-013 SHALL, on conflict with ROUND_ROBIN=1, grant the side opposite to last_owner; with ROUND_ROBIN=0, always grant data.
REQ-014 SHALL update last_owner to the granted side on every granted cycle, and hold it otherwise.
REQ-015 SHALL drive ram_enabled = inst_grant | data_grant, and mux the winner's strobe, address and write data onto ram_*.
REQ-016 SHALL drive ram_write_strobe, ram_address and ram_write_data to 0 when no grant is issued.
REQ-017 SHALL register {read_pending, read_owner} on each grant; read_pending = (winner strobe == 0).
REQ-018 SHALL assert <owner>_read_valid for exactly one cycle, the cycle after a read grant, with <owner>_read_data = ram_read_data.
REQ-019 SHALL hold the non-owner read_valid at 0, and SHALL hold both read_data buses at 0 when the corresponding read_valid is 0.
REQ-020 SHALL never assert read_valid for a write grant.
REQ-021 SHALL allow back-to-back grants every cycle (full throughput); a new grant in cycle N+1 does not disturb the return of the grant from cycle N.
REQ-022 SHALL treat the loser as stalled: the requester holds request, address and data stable until granted; the arbiter keeps no queue.
REQ-023 SHALL guarantee that, with ROUND_ROBIN=1 and both sides requesting continuously, grants strictly alternate, so neither side waits more than 1 cycle.

Reset
REQ-024 SHALL, while reset is high, force inst_grant, data_grant and ram_enabled to 0, both read_valid signals to 0, and both read_data buses to 0.
REQ-025 SHALL initialise last_owner to inst so that the first conflict after reset grants data, and SHALL clear read_pending.
REQ-026 SHALL discard any read in flight when reset is asserted mid-operation: no read_valid in the cycle after reset.

Verification
REQ-027 Inst-only read: inst_request=1, strobe=0, address=0xbfc00000, ram_read_data=0x3c1d0001 next cycle -> inst_grant=1 same cycle; ram_address=0xbfc00000; inst_read_valid=1 with inst_read_data=0x3c1d0001 in cycle+1; no data_* activity.
REQ-028 First conflict after reset, ROUND_ROBIN=1: both reads request -> data granted in cycle 0, inst in cycle 1; data_read_valid in cycle 1 and inst_read_valid in cycle 2, each carrying its own ram_read_data.
REQ-029 Sustained conflict for 6 cycles -> grants D,I,D,I,D,I; ram_enabled=1 every cycle.
REQ-030 With ROUND_ROBIN=0 and sustained conflict for 4 cycles -> data granted all 4 cycles; inst_grant stays 0.
REQ-031 Data write: strobe=0xf, address=0x1000, data=0xdeadbeef -> ram_write_strobe=0xf with matching address and data in the grant cycle; data_read_valid stays 0 in the next cycle.
REQ-032 Reset asserted in the cycle after a read grant -> no read_valid and all outputs 0; after reset deasserts, the first conflict is granted to data.
